// File: rtl/led_pattern_gen.sv
// LED animation generator: prescaled stepping of fill/drain/chase/bounce/count
// patterns on a WIDTH-bit bus, with one-cycle step and wrap pulses.
//
// mode_q | meaning
// 0      | FILL   - shift ones in until full, then clear
// 1      | DRAIN  - shift zeros in until empty, then refill
// 2      | CHASE  - single rotating one
// 3      | BOUNCE - single one sweeping up then down
// 4      | COUNT  - binary up/down counter
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             wrap
);

    localparam logic [2:0] MODE_FILL   = 3'd0;
    localparam logic [2:0] MODE_DRAIN  = 3'd1;
    localparam logic [2:0] MODE_CHASE  = 3'd2;
    localparam logic [2:0] MODE_BOUNCE = 3'd3;
    localparam logic [2:0] MODE_COUNT  = 3'd4;

    localparam logic [WIDTH-1:0] PAT_ZERO = '0;
    localparam logic [WIDTH-1:0] PAT_ONES = '1;
    localparam logic [WIDTH-1:0] PAT_LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] PAT_MSB  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_led;
    logic [DIV_W-1:0] r_cnt;
    logic [2:0]       r_mode_q;
    logic             r_bdir_down;
    logic             r_step;
    logic             r_wrap;

    logic [2:0]       w_mode_eff;
    logic [WIDTH-1:0] w_start_pat;
    logic [WIDTH-1:0] w_pat_nxt;
    logic             w_pat_wrap;
    logic             w_pat_bdir_down;

    logic [WIDTH-1:0] w_led_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [2:0]       w_mode_q_nxt;
    logic             w_bdir_down_nxt;
    logic             w_step_nxt;
    logic             w_wrap_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led       <= '0;
            r_cnt       <= '0;
            r_mode_q    <= MODE_FILL;
            r_bdir_down <= 1'b0;
            r_step      <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_led       <= w_led_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mode_q    <= w_mode_q_nxt;
            r_bdir_down <= w_bdir_down_nxt;
            r_step      <= w_step_nxt;
            r_wrap      <= w_wrap_nxt;
        end
    end

    // Pattern arithmetic: start value for the requested mode and the
    // candidate next value for the current mode if a tick occurs.
    always_comb begin
        w_mode_eff      = (mode > MODE_COUNT) ? MODE_FILL : mode;
        w_start_pat     = PAT_ZERO;
        w_pat_nxt       = r_led;
        w_pat_wrap      = 1'b0;
        w_pat_bdir_down = r_bdir_down;

        case (w_mode_eff)
            MODE_DRAIN:  w_start_pat = PAT_ONES;
            MODE_CHASE:  w_start_pat = dir ? PAT_MSB : PAT_LSB;
            MODE_BOUNCE: w_start_pat = PAT_LSB;
            default:     w_start_pat = PAT_ZERO;
        endcase

        case (r_mode_q)
            MODE_FILL: begin
                if (r_led == PAT_ONES) begin
                    w_pat_nxt  = PAT_ZERO;
                    w_pat_wrap = 1'b1;
                end else if (dir) begin
                    w_pat_nxt = {1'b1, r_led[WIDTH-1:1]};
                end else begin
                    w_pat_nxt = {r_led[WIDTH-2:0], 1'b1};
                end
            end
            MODE_DRAIN: begin
                if (r_led == PAT_ZERO) begin
                    w_pat_nxt  = PAT_ONES;
                    w_pat_wrap = 1'b1;
                end else if (dir) begin
                    w_pat_nxt = {1'b0, r_led[WIDTH-1:1]};
                end else begin
                    w_pat_nxt = {r_led[WIDTH-2:0], 1'b0};
                end
            end
            MODE_CHASE: begin
                w_pat_nxt  = dir ? {r_led[0], r_led[WIDTH-1:1]}
                                 : {r_led[WIDTH-2:0], r_led[WIDTH-1]};
                w_pat_wrap = (w_pat_nxt == (dir ? PAT_MSB : PAT_LSB));
            end
            MODE_BOUNCE: begin
                // Direction flips on the step that lands on an end bit.
                if (!r_bdir_down) begin
                    w_pat_nxt       = r_led << 1;
                    w_pat_bdir_down = w_pat_nxt[WIDTH-1];
                end else begin
                    w_pat_nxt       = r_led >> 1;
                    w_pat_wrap      = w_pat_nxt[0];
                    w_pat_bdir_down = ~w_pat_nxt[0];
                end
            end
            MODE_COUNT: begin
                w_pat_nxt  = dir ? (r_led - WIDTH'(1)) : (r_led + WIDTH'(1));
                w_pat_wrap = (w_pat_nxt == (dir ? PAT_ONES : PAT_ZERO));
            end
            default: begin
                w_pat_nxt = r_led;
            end
        endcase
    end

    // Next-state: mode change beats tick; disabled cycles freeze everything.
    always_comb begin
        w_led_nxt       = r_led;
        w_cnt_nxt       = r_cnt;
        w_mode_q_nxt    = r_mode_q;
        w_bdir_down_nxt = r_bdir_down;
        w_step_nxt      = 1'b0;
        w_wrap_nxt      = 1'b0;

        if (w_mode_eff != r_mode_q) begin
            w_led_nxt       = w_start_pat;
            w_cnt_nxt       = '0;
            w_mode_q_nxt    = w_mode_eff;
            w_bdir_down_nxt = 1'b0;
        end else if (en) begin
            if (r_cnt >= div) begin
                w_cnt_nxt       = '0;
                w_led_nxt       = w_pat_nxt;
                w_bdir_down_nxt = w_pat_bdir_down;
                w_step_nxt      = 1'b1;
                w_wrap_nxt      = w_pat_wrap;
            end else begin
                w_cnt_nxt = r_cnt + DIV_W'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        led  = r_led;
        step = r_step;
        wrap = r_wrap;
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: vector table, hand sequences for the timing
// corner cases, then random stimulus against an arithmetic reference model.
module tb_led_pattern_gen;

    localparam int W    = 8;
    localparam int DW   = 24;
    localparam int FULL = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic          dir = 1'b0;
    logic [DW-1:0] div = '0;
    logic [W-1:0]  led;
    logic          step;
    logic          wrap;

    int vectors = 0;
    int miscompares = 0;

    int m_led = 0, m_cnt = 0, m_mode = 0, m_bpos = 0, m_bup = 1;
    int m_step = 0, m_wrap = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .mode (mode),
        .dir  (dir),
        .div  (div),
        .led  (led),
        .step (step),
        .wrap (wrap)
    );

    typedef struct {
        logic          rst_n;
        logic          en;
        logic [2:0]    mode;
        logic          dir;
        logic [DW-1:0] div;
        logic [W-1:0]  led;
        logic          step;
        logic          wrap;
    } vec_t;

    vec_t tbl[21];

    // Reference: pattern rules written as integer arithmetic on the LED value.
    task automatic model_edge();
        int me;
        if (!rst_n) begin
            m_led = 0; m_cnt = 0; m_mode = 0; m_bpos = 0; m_bup = 1;
            m_step = 0; m_wrap = 0;
            return;
        end
        me = (int'(mode) > 4) ? 0 : int'(mode);
        m_step = 0;
        m_wrap = 0;
        if (me != m_mode) begin
            m_mode = me; m_cnt = 0; m_bup = 1; m_bpos = 0;
            case (me)
                1: m_led = FULL;
                2: m_led = dir ? HALF : 1;
                3: m_led = 1;
                default: m_led = 0;
            endcase
        end else if (en) begin
            if (m_cnt >= int'(div)) begin
                m_cnt = 0;
                m_step = 1;
                case (m_mode)
                    0: if (m_led == FULL) begin m_led = 0; m_wrap = 1; end
                       else m_led = dir ? (m_led / 2 + HALF) : ((m_led * 2 + 1) & FULL);
                    1: if (m_led == 0) begin m_led = FULL; m_wrap = 1; end
                       else m_led = dir ? (m_led / 2) : ((m_led * 2) & FULL);
                    2: begin
                        m_led = dir ? (m_led / 2 + (m_led % 2) * HALF)
                                    : (((m_led * 2) & FULL) + m_led / HALF);
                        m_wrap = (m_led == (dir ? HALF : 1)) ? 1 : 0;
                    end
                    3: begin
                        m_bpos = m_bpos + (m_bup ? 1 : -1);
                        if (m_bpos == W - 1) m_bup = 0;
                        if (m_bpos == 0) begin m_bup = 1; m_wrap = 1; end
                        m_led = 1 << m_bpos;
                    end
                    default: begin
                        m_led = dir ? ((m_led + FULL) & FULL) : ((m_led + 1) & FULL);
                        m_wrap = (m_led == (dir ? FULL : 0)) ? 1 : 0;
                    end
                endcase
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic clk_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] e_led,
                         input logic e_step, input logic e_wrap);
        vectors++;
        if (led !== e_led || step !== e_step || wrap !== e_wrap) begin
            miscompares++;
            $display("FAIL %s: got led=%h step=%b wrap=%b, want led=%h step=%b wrap=%b",
                     name, led, step, wrap, e_led, e_step, e_wrap);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic cycles_to_step(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            clk_edge();
            if (step === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clk_edge();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int pos;
        logic [W-1:0] e;

        // rst_n, en, mode, dir, div, led, step, wrap
        tbl[0]  = '{1'b0, 1'b1, 3'd0, 1'b0, 24'd0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 3'd0, 1'b0, 24'd0, 8'h01, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 3'd0, 1'b0, 24'd0, 8'h03, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 3'd0, 1'b0, 24'd0, 8'h07, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 3'd0, 1'b0, 24'd0, 8'h0F, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 3'd0, 1'b0, 24'd0, 8'h1F, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 3'd0, 1'b0, 24'd0, 8'h3F, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 3'd0, 1'b0, 24'd0, 8'h7F, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 3'd0, 1'b0, 24'd0, 8'hFF, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'd0, 1'b0, 24'd0, 8'h00, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 3'd4, 1'b1, 24'd0, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 3'd4, 1'b1, 24'd0, 8'hFF, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 3'd4, 1'b1, 24'd0, 8'hFE, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 3'd4, 1'b1, 24'd0, 8'hFD, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 3'd6, 1'b0, 24'd0, 8'h00, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 3'd6, 1'b0, 24'd0, 8'h01, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 3'd2, 1'b1, 24'd0, 8'h80, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 3'd2, 1'b1, 24'd0, 8'h40, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 3'd2, 1'b1, 24'd0, 8'h00, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 3'd2, 1'b0, 24'd0, 8'h01, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 1'b1, 3'd2, 1'b0, 24'd0, 8'h02, 1'b1, 1'b0};

        for (int i = 0; i < 21; i++) begin
            rst_n = tbl[i].rst_n;
            en    = tbl[i].en;
            mode  = tbl[i].mode;
            dir   = tbl[i].dir;
            div   = tbl[i].div;
            clk_edge();
            check($sformatf("table[%0d]", i), tbl[i].led, tbl[i].step, tbl[i].wrap);
        end

        // Prescaler spacing and freeze with en low mid-period
        mode = 3'd0; dir = 1'b0; div = 24'd3; en = 1'b1;
        do_reset();
        check("presc_reset", 8'h00, 1'b0, 1'b0);
        cycles_to_step(20, n);
        check_int("presc_first_gap", n, 4);
        check("presc_led1", 8'h01, 1'b1, 1'b0);
        cycles_to_step(20, n);
        check_int("presc_second_gap", n, 4);
        check("presc_led2", 8'h03, 1'b1, 1'b0);
        clk_edge();
        clk_edge();
        check("presc_mid", 8'h03, 1'b0, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clk_edge();
            check("freeze", 8'h03, 1'b0, 1'b0);
        end
        en = 1'b1;
        cycles_to_step(20, n);
        check_int("freeze_resume_gap", n, 2);
        check("freeze_resume_led", 8'h07, 1'b1, 1'b0);

        // Mode change mid-run: FILL at 0F switches to CHASE toward LSB
        div = '0;
        do_reset();
        for (int i = 0; i < 4; i++) clk_edge();
        check("mc_fill_0f", 8'h0F, 1'b1, 1'b0);
        mode = 3'd2; dir = 1'b1;
        clk_edge();
        check("mc_load", 8'h80, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            clk_edge();
            e = 8'h80 >> k;
            check("mc_chase", e, 1'b1, 1'b0);
        end
        clk_edge();
        check("mc_chase_wrap", 8'h80, 1'b1, 1'b1);

        // BOUNCE with dir toggled at random: position follows a triangle wave
        mode = 3'd3;
        clk_edge();
        check("bounce_load", 8'h01, 1'b0, 1'b0);
        for (int k = 1; k <= 28; k++) begin
            dir = 1'($urandom);
            clk_edge();
            pos = k % (2 * W - 2);
            if (pos > W - 1) pos = 2 * W - 2 - pos;
            e = W'(1) << pos;
            check($sformatf("bounce[%0d]", k), e, 1'b1, (pos == 0));
        end

        // Random stimulus against the reference model
        rst_n = 1'b0;
        clk_edge();
        check("rand_reset", W'(m_led), m_step[0], m_wrap[0]);
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom % 200) != 0;
            if ($urandom % 40 == 0) mode = 3'($urandom % 8);
            if ($urandom % 8 == 0) dir = ~dir;
            en = ($urandom % 10) != 0;
            if ($urandom % 50 == 0) div = DW'($urandom % 4);
            clk_edge();
            check($sformatf("rand[%0d]", i), W'(m_led), m_step[0], m_wrap[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
